mem_access_stage: RTL and testbench
===================================

# mem_access_stage

MEM-stage controller of the MIPS pipeline, directly downstream of the EX/MEM pipeline register. It consumes the EX/MEM outputs, performs the data-memory load or store over a req/ack handshake, and stalls the upstream pipeline while an access is outstanding. It also contains the MEM/WB pipeline register that feeds writeback.

## Interface
- TIMEOUT_CYCLES, 255: maximum BUSY cycles without `dmem_ack` before the access is abandoned (≥1, 8-bit counter).
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous reset, active-high. One clock; reset is asynchronous and active-high.
- PC_next_MEM  in  32  from EX/MEM.
- MemtoReg_MEM, RegWrite_MEM  in  1 each  from EX/MEM.
- MemRead_MEM, MemWrite_MEM  in  1 each  access type from EX/MEM.
- writeAddr_MEM  in  5  destination register.
- ALU_result_MEM  in  32  effective address or result.
- writeData_MEM  in  32  store data.
- stall_MEM  out  1  combinational; upstream (IF/ID/EX and EX/MEM registers) holds while high.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  address.
- dmem_wdata  out  32  store data.
- dmem_ack  in  1  one-cycle completion pulse.
- dmem_rdata  in  32  load data, valid when `dmem_ack` is high.
- PC_next_WB, ALU_result_WB, readData_WB  out  32 each  MEM/WB register.
- writeAddr_WB  out  5  MEM/WB register.
- MemtoReg_WB, RegWrite_WB, mem_err_WB  out  1 each  MEM/WB register.

## Operation
- Access = `MemRead_MEM | MemWrite_MEM`. If both are set, the access is a store and `readData_WB` = 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, no access: `stall_MEM` = 0. The MEM/WB register captures the inputs and sets `readData_WB` = 0.
  - IDLE, access: `stall_MEM` = 1. Next state is BUSY and the timeout counter clears.
  - BUSY: `dmem_req` = 1, `stall_MEM` = 1. Address, we and wdata are driven from the held EX/MEM inputs.
    - `dmem_ack` = 1: latch `dmem_rdata` (loads only) and go to DONE.
    - Counter reaches TIMEOUT_CYCLES: go to DONE with the error flag set and latched data = 32'hDEAD_BEEF.
  - DONE: `stall_MEM` = 0. The MEM/WB register captures the inputs plus the latched data and error flag. Next state is IDLE.
- While `stall_MEM` = 1, MEM/WB loads a bubble: `RegWrite_WB` = 0, `MemtoReg_WB` = 0, `mem_err_WB` = 0. The other WB fields hold.
- On error, `RegWrite_WB` is forced to 0.
- `dmem_req`, `dmem_we`, `dmem_addr` and `dmem_wdata` are stable from request to ack. They are 0 outside BUSY.
- `dmem_ack` in IDLE or DONE is ignored.

## Timing
- Non-memory op: 1 cycle to WB, no stall.
- Memory op: minimum 3 cycles in MEM (IDLE → BUSY with same-cycle ack → DONE). `stall_MEM` is high for 2 cycles in that case.
- Each extra cycle without ack adds one stall cycle, up to TIMEOUT_CYCLES.
- Reset values:
  - FSM = IDLE, counter = 0.
  - `dmem_req` = `dmem_we` = 0, `dmem_addr` = `dmem_wdata` = 0.
  - `stall_MEM` = 0.
  - All WB outputs = 0.
- `rst` mid-access: `dmem_req` drops immediately (asynchronous). The access is abandoned and no WB write results. A late `dmem_ack` after reset is ignored.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: an access with `ALU_result_MEM[1:0]` ≠ 0 issues no request. It goes IDLE → DONE with `mem_err_WB` = 1, `RegWrite_WB` = 0 and `readData_WB` = 32'hDEAD_BEEF (2 cycles, 1 stall cycle).
- `MEM_ALIGN_CHECK_EN` undefined: no check. `dmem_addr` = `ALU_result_MEM` unmodified.

## Structure
- Shared package `mips_pkg`:
  - FSM state enum `mem_state_t` (IDLE, BUSY, DONE).
  - Constant `MEM_ERR_DATA` = 32'hDEAD_BEEF.
  - Counter width constant (8).
- Sub-module `Reg_MEM2WB`: the MEM/WB register, with bubble-insert input and asynchronous reset.
- FSM and timeout counter live in the top module.

## Test plan
- Reset, then ALU op (`RegWrite_MEM` = 1, addr 5, result 0x1234): next cycle `RegWrite_WB` = 1, `writeAddr_WB` = 5, `ALU_result_WB` = 0x1234, `stall_MEM` never high.
- Load at 0x100, ack on the first BUSY cycle with rdata 0xCAFEF00D:
  - `stall_MEM` high for 2 cycles.
  - `dmem_req` high for 1 cycle with `dmem_addr` = 0x100, `dmem_we` = 0.
  - WB then shows `readData_WB` = 0xCAFEF00D and `MemtoReg_WB` = 1.
- Store 0xA5A5A5A5 to 0x200, ack delayed 4 cycles: `dmem_we` = 1 and `dmem_wdata` stable throughout, `stall_MEM` high for 5 cycles, `mem_err_WB` = 0.
- Load with no ack, TIMEOUT_CYCLES = 4: after 4 BUSY cycles, DONE; `mem_err_WB` = 1, `RegWrite_WB` = 0, `readData_WB` = 0xDEADBEEF.
- `rst` pulsed while in BUSY: `dmem_req` = 0 in the same cycle, all WB outputs = 0. An ack after reset causes no WB change.
- With `MEM_ALIGN_CHECK_EN` defined, load at 0x102: `dmem_req` never asserted, `mem_err_WB` = 1 after 2 cycles. Without the macro: request issued with `dmem_addr` = 0x102.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants: MEM-stage FSM state,
// data-memory error pattern, timeout counter width and MEM/WB payload.
package mips_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned RADDR_W   = 5;
  localparam int unsigned MEM_CNT_W = 8;

  localparam logic [XLEN-1:0] MEM_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [XLEN-1:0]    pc_next;
    logic [XLEN-1:0]    alu_result;
    logic [XLEN-1:0]    read_data;
    logic [RADDR_W-1:0] write_addr;
    logic               mem_to_reg;
    logic               reg_write;
    logic               mem_err;
  } mem_wb_t;

endpackage

// File: rtl/mem_access_stage_mem2wb.sv
// MEM/WB pipeline register; a bubble clears the control bits and holds
// the data fields.
module Reg_MEM2WB
  import mips_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    bubble_i,
  input  mem_wb_t wb_i,
  output mem_wb_t wb_o
);

  mem_wb_t wb_q;
  mem_wb_t wb_d;

  always_comb begin
    wb_d = wb_q;
    if (bubble_i) begin
      wb_d.reg_write  = 1'b0;
      wb_d.mem_to_reg = 1'b0;
      wb_d.mem_err    = 1'b0;
    end else begin
      wb_d = wb_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wb_q <= '0;
    else     wb_q <= wb_d;
  end

  assign wb_o = wb_q;

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: data-memory req/ack controller with timeout, upstream
// stall and MEM/WB register. Optional macro: MEM_ALIGN_CHECK_EN.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     PC_next_MEM,
  input  logic                MemtoReg_MEM,
  input  logic                RegWrite_MEM,
  input  logic                MemRead_MEM,
  input  logic                MemWrite_MEM,
  input  logic [RADDR_W-1:0]  writeAddr_MEM,
  input  logic [XLEN-1:0]     ALU_result_MEM,
  input  logic [XLEN-1:0]     writeData_MEM,
  output logic                stall_MEM,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [XLEN-1:0]     dmem_addr,
  output logic [XLEN-1:0]     dmem_wdata,
  input  logic                dmem_ack,
  input  logic [XLEN-1:0]     dmem_rdata,
  output logic [XLEN-1:0]     PC_next_WB,
  output logic [XLEN-1:0]     ALU_result_WB,
  output logic [XLEN-1:0]     readData_WB,
  output logic [RADDR_W-1:0]  writeAddr_WB,
  output logic                MemtoReg_WB,
  output logic                RegWrite_WB,
  output logic                mem_err_WB
);

  localparam logic [MEM_CNT_W-1:0] TO_LAST = MEM_CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t           state_q, state_d;
  logic [MEM_CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]      rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [XLEN-1:0]      addr_q, addr_d;
  logic [XLEN-1:0]      wdata_q, wdata_d;
  logic                 stall_c;
  logic                 access_c, is_load_c, misalign_c;
  mem_wb_t              wb_in, wb_out;

  assign access_c  = MemRead_MEM | MemWrite_MEM;
  assign is_load_c = MemRead_MEM & ~MemWrite_MEM;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_c = access_c & (ALU_result_MEM[1:0] != 2'b00);
`else
  assign misalign_c = 1'b0;
`endif

  // Next state, timeout counter and latched access result
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (access_c) begin
          stall_c = 1'b1;
          cnt_d   = '0;
          if (misalign_c) begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = MEM_ERR_DATA;
          end else begin
            state_d = BUSY;
            err_d   = 1'b0;
            rdata_d = '0;
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        cnt_d   = MEM_CNT_W'(cnt_q + 1'b1);
        if (dmem_ack) begin
          state_d = DONE;
          err_d   = 1'b0;
          rdata_d = is_load_c ? dmem_rdata : '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = MEM_ERR_DATA;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Upstream is stalled throughout BUSY, so the held inputs stay stable
    req_d   = (state_d == BUSY);
    we_d    = req_d & MemWrite_MEM;
    addr_d  = req_d ? ALU_result_MEM : '0;
    wdata_d = req_d ? writeData_MEM  : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // WB payload: access result only in DONE, plain pass-through otherwise
  always_comb begin
    wb_in.pc_next    = PC_next_MEM;
    wb_in.alu_result = ALU_result_MEM;
    wb_in.write_addr = writeAddr_MEM;
    wb_in.mem_to_reg = MemtoReg_MEM;
    wb_in.read_data  = '0;
    wb_in.mem_err    = 1'b0;
    wb_in.reg_write  = RegWrite_MEM;
    if (state_q == DONE) begin
      wb_in.read_data = rdata_q;
      wb_in.mem_err   = err_q;
      wb_in.reg_write = RegWrite_MEM & ~err_q;
    end
  end

  Reg_MEM2WB u_mem2wb (
    .clk      (clk),
    .rst      (rst),
    .bubble_i (stall_c),
    .wb_i     (wb_in),
    .wb_o     (wb_out)
  );

  assign stall_MEM     = stall_c;
  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign PC_next_WB    = wb_out.pc_next;
  assign ALU_result_WB = wb_out.alu_result;
  assign readData_WB   = wb_out.read_data;
  assign writeAddr_WB  = wb_out.write_addr;
  assign MemtoReg_WB   = wb_out.mem_to_reg;
  assign RegWrite_WB   = wb_out.reg_write;
  assign mem_err_WB    = wb_out.mem_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed scoreboard bench for mem_access_stage (timeout shortened to 4).
module tb_mem_access_stage;
  import mips_pkg::*;

  localparam int unsigned TO = 4;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_next_MEM, ALU_result_MEM, writeData_MEM;
  logic        MemtoReg_MEM, RegWrite_MEM, MemRead_MEM, MemWrite_MEM;
  logic [4:0]  writeAddr_MEM, writeAddr_WB;
  logic        stall_MEM, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] PC_next_WB, ALU_result_WB, readData_WB;
  logic        MemtoReg_WB, RegWrite_WB, mem_err_WB;

  int n_cmp = 0;
  int n_bad = 0;
  mem_wb_t sb[$];

  mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .PC_next_MEM(PC_next_MEM), .MemtoReg_MEM(MemtoReg_MEM), .RegWrite_MEM(RegWrite_MEM),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM), .writeAddr_MEM(writeAddr_MEM),
    .ALU_result_MEM(ALU_result_MEM), .writeData_MEM(writeData_MEM),
    .stall_MEM(stall_MEM), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .PC_next_WB(PC_next_WB), .ALU_result_WB(ALU_result_WB), .readData_WB(readData_WB),
    .writeAddr_WB(writeAddr_WB), .MemtoReg_WB(MemtoReg_WB), .RegWrite_WB(RegWrite_WB),
    .mem_err_WB(mem_err_WB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic m2r, input logic rw,
                       input logic [4:0] wa, input logic [31:0] pc, input logic [31:0] addr,
                       input logic [31:0] wd);
    MemRead_MEM    = rd;
    MemWrite_MEM   = wr;
    MemtoReg_MEM   = m2r;
    RegWrite_MEM   = rw;
    writeAddr_MEM  = wa;
    PC_next_MEM    = pc;
    ALU_result_MEM = addr;
    writeData_MEM  = wd;
  endtask

  task automatic chk_wb(input string tag, input mem_wb_t e);
    chk({tag, ".pc"},    PC_next_WB,    e.pc_next);
    chk({tag, ".alu"},   ALU_result_WB, e.alu_result);
    chk({tag, ".rdata"}, readData_WB,   e.read_data);
    chk({tag, ".wa"},    32'(writeAddr_WB), 32'(e.write_addr));
    chk({tag, ".m2r"},   32'(MemtoReg_WB),  32'(e.mem_to_reg));
    chk({tag, ".rw"},    32'(RegWrite_WB),  32'(e.reg_write));
    chk({tag, ".err"},   32'(mem_err_WB),   32'(e.mem_err));
  endtask

  // ack_at: BUSY cycle (1-based) carrying the ack; 0 = never; -1 = ack held high every cycle
  task automatic run_op(input string tag, input logic rd, input logic wr, input logic m2r,
                        input logic rw, input logic [4:0] wa, input logic [31:0] pc,
                        input logic [31:0] addr, input logic [31:0] wd, input int ack_at,
                        input logic [31:0] rdat, input int exp_stall, input int exp_req);
    mem_wb_t e;
    mem_wb_t got;
    int n_stall = 0;
    int n_req = 0;
    bit done = 1'b0;
    bit acc, mis, tmo;
    acc = rd | wr;
    mis = ALIGN_EN && acc && (addr[1:0] != 2'b00);
    tmo = acc && !mis && (ack_at == 0);
    e.pc_next    = pc;
    e.alu_result = addr;
    e.write_addr = wa;
    e.mem_to_reg = m2r;
    e.mem_err    = mis | tmo;
    e.reg_write  = rw & ~e.mem_err;
    e.read_data  = e.mem_err ? 32'hDEAD_BEEF : ((rd & ~wr) ? rdat : 32'h0);
    sb.push_back(e);
    drive(rd, wr, m2r, rw, wa, pc, addr, wd);
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      #1;
      if (cyc > 0 && stall_MEM) begin
        chk({tag, ".bubble_rw"},  32'(RegWrite_WB), 32'h0);
        chk({tag, ".bubble_m2r"}, 32'(MemtoReg_WB), 32'h0);
        chk({tag, ".bubble_err"}, 32'(mem_err_WB),  32'h0);
      end
      if (stall_MEM) n_stall++;
      if (dmem_req) begin
        n_req++;
        chk({tag, ".addr"},  dmem_addr,  addr);
        chk({tag, ".we"},    32'(dmem_we), 32'(wr));
        chk({tag, ".wdata"}, dmem_wdata, wd);
      end else begin
        chk({tag, ".idle_bus"}, {dmem_addr | dmem_wdata}, 32'h0);
        chk({tag, ".idle_we"},  32'(dmem_we), 32'h0);
      end
      dmem_ack   = (ack_at < 0) || (dmem_req && n_req == ack_at);
      dmem_rdata = dmem_ack ? rdat : $urandom();
      if (!stall_MEM) done = 1'b1;
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
    end
    chk({tag, ".retired"},   32'(done),    32'h1);
    chk({tag, ".stall_cnt"}, 32'(n_stall), 32'(exp_stall));
    chk({tag, ".req_cnt"},   32'(n_req),   32'(exp_req));
    got = sb.pop_front();
    chk_wb(tag, got);
  endtask

  initial begin
    rst        = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.stall", 32'(stall_MEM), 32'h0);
    chk("rst.req",   32'(dmem_req),  32'h0);
    chk("rst.we",    32'(dmem_we),   32'h0);
    chk("rst.addr",  dmem_addr,      32'h0);
    chk("rst.wdata", dmem_wdata,     32'h0);
    chk_wb("rst.wb", '0);
    rst = 1'b0;

    //      tag      rd    wr    m2r   rw    wa     pc      addr          wdata         ack rdata          stall req
    run_op("alu",   1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  32'h04, 32'h0000_1234, 32'h0,         0, 32'h0,          0, 0);
    run_op("alu_ak",1'b0, 1'b0, 1'b0, 1'b1, 5'd6,  32'h08, 32'h0000_5678, 32'h0,        -1, 32'hFFFF_FFFF,  0, 0);
    run_op("load",  1'b1, 1'b0, 1'b1, 1'b1, 5'd8,  32'h0C, 32'h0000_0100, 32'h1357_9BDF, 1, 32'hCAFE_F00D,  2, 1);
    run_op("store", 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h10, 32'h0000_0200, 32'hA5A5_A5A5, 4, 32'h7777_7777,  5, 4);
    run_op("both",  1'b1, 1'b1, 1'b0, 1'b0, 5'd3,  32'h14, 32'h0000_0204, 32'h0BAD_F00D, 2, 32'h1234_5678,  3, 2);
    run_op("tmo",   1'b1, 1'b0, 1'b1, 1'b1, 5'd9,  32'h18, 32'h0000_0300, 32'h0,         0, 32'h0,          5, 4);
    run_op("ld_ak", 1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'h1C, 32'h0000_0104, 32'h0,        -1, 32'h600D_D00D,  2, 1);
    if (ALIGN_EN)
      run_op("mis", 1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 32'h20, 32'h0000_0102, 32'h0,         1, 32'h4444_4444,  1, 0);
    else
      run_op("mis", 1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 32'h20, 32'h0000_0102, 32'h0,         1, 32'h4444_4444,  2, 1);

    // Reset in the middle of a load, then a stray ack
    drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'h24, 32'h0000_0400, 32'h0);
    @(posedge clk);
    #1;
    chk("mid.req_before", 32'(dmem_req), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("mid.req", 32'(dmem_req), 32'h0);
    chk("mid.addr", dmem_addr, 32'h0);
    chk_wb("mid.wb", '0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1111_2222;
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    chk("late.rdata", readData_WB, 32'h0);
    chk("late.rw",    32'(RegWrite_WB), 32'h0);
    chk("late.err",   32'(mem_err_WB),  32'h0);
    chk("late.req",   32'(dmem_req),    32'h0);
    chk("late.stall", 32'(stall_MEM),   32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
